// File: rtl/alu_decode_stage.sv
// alu_decode_stage: RV32I integer ALU decode stage with a 2-entry skid buffer.
// Decodes R-type (0110011) and I-type (0010011) ALU instructions into the
// 6-bit ALU control code, the 12-bit immediate and the register indices.
// in_ready is registered and equals "skid entry empty".
// Optional feature: define DECODE_ILLEGAL_CNT_EN to add the saturating
// illegal_count output (ILL_CNT_W bits wide).
module alu_decode_stage #(
    parameter int unsigned ILL_CNT_W = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_instr,
    input  logic        flush,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [5:0]  out_alu_control,
    output logic [11:0] out_imm_val,
    output logic [4:0]  out_rd,
    output logic [4:0]  out_rs1,
    output logic [4:0]  out_rs2,
    output logic        out_uses_rs2,
    output logic        out_illegal
`ifdef DECODE_ILLEGAL_CNT_EN
    ,
    output logic [ILL_CNT_W-1:0] illegal_count
`endif
);

    // Opcodes handled by this stage
    localparam logic [6:0] OpRType = 7'b0110011;
    localparam logic [6:0] OpIType = 7'b0010011;

    localparam logic [6:0] Funct7Base = 7'b0000000;
    localparam logic [6:0] Funct7Alt  = 7'b0100000;

    // ALU control codes
    localparam logic [5:0] AluAdd   = 6'b000000;
    localparam logic [5:0] AluSlt   = 6'b000001;
    localparam logic [5:0] AluSltu  = 6'b000010;
    localparam logic [5:0] AluAnd   = 6'b000011;
    localparam logic [5:0] AluOr    = 6'b000100;
    localparam logic [5:0] AluXor   = 6'b000101;
    localparam logic [5:0] AluSll   = 6'b000110;
    localparam logic [5:0] AluSrl   = 6'b000111;
    localparam logic [5:0] AluSub   = 6'b001000;
    localparam logic [5:0] AluSra   = 6'b001001;
    localparam logic [5:0] AluAddi  = 6'b111111;
    localparam logic [5:0] AluSlti  = 6'b111110;
    localparam logic [5:0] AluSltiu = 6'b111101;
    localparam logic [5:0] AluAndi  = 6'b111100;
    localparam logic [5:0] AluOri   = 6'b111011;
    localparam logic [5:0] AluXori  = 6'b111010;
    // SRLI and SRAI share one code; execute tells them apart by imm[10]
    localparam logic [5:0] AluSrxi  = 6'b111000;

    typedef struct packed {
        logic [5:0]  alu_control;
        logic [11:0] imm_val;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic        uses_rs2;
        logic        illegal;
    } entry_t;

    // Instruction fields
    logic [6:0] w_opcode;
    logic [4:0] w_rd_f;
    logic [2:0] w_funct3;
    logic [4:0] w_rs1_f;
    logic [4:0] w_rs2_f;
    logic [6:0] w_funct7;

    assign w_opcode = in_instr[6:0];
    assign w_rd_f   = in_instr[11:7];
    assign w_funct3 = in_instr[14:12];
    assign w_rs1_f  = in_instr[19:15];
    assign w_rs2_f  = in_instr[24:20];
    assign w_funct7 = in_instr[31:25];

    entry_t w_dec;

    // Combinational decode of the incoming instruction word
    always_comb begin
        w_dec     = '0;
        w_dec.rs1 = w_rs1_f;
        case (w_opcode)
            OpRType: begin
                w_dec.rs2      = w_rs2_f;
                w_dec.uses_rs2 = 1'b1;
                if (w_funct7 == Funct7Base) begin
                    unique case (w_funct3)
                        3'b000: w_dec.alu_control = AluAdd;
                        3'b001: w_dec.alu_control = AluSll;
                        3'b010: w_dec.alu_control = AluSlt;
                        3'b011: w_dec.alu_control = AluSltu;
                        3'b100: w_dec.alu_control = AluXor;
                        3'b101: w_dec.alu_control = AluSrl;
                        3'b110: w_dec.alu_control = AluOr;
                        3'b111: w_dec.alu_control = AluAnd;
                    endcase
                end else if ((w_funct7 == Funct7Alt) && (w_funct3 == 3'b000)) begin
                    w_dec.alu_control = AluSub;
                end else if ((w_funct7 == Funct7Alt) && (w_funct3 == 3'b101)) begin
                    w_dec.alu_control = AluSra;
                end else begin
                    w_dec.illegal = 1'b1;
                end
            end
            OpIType: begin
                w_dec.imm_val = in_instr[31:20];
                unique case (w_funct3)
                    3'b000: w_dec.alu_control = AluAddi;
                    3'b010: w_dec.alu_control = AluSlti;
                    3'b011: w_dec.alu_control = AluSltiu;
                    3'b100: w_dec.alu_control = AluXori;
                    3'b110: w_dec.alu_control = AluOri;
                    3'b111: w_dec.alu_control = AluAndi;
                    3'b001: begin
                        if (w_funct7 == Funct7Base) begin
                            w_dec.alu_control = AluSll;
                        end else begin
                            w_dec.illegal = 1'b1;
                        end
                    end
                    3'b101: begin
                        if ((w_funct7 == Funct7Base) || (w_funct7 == Funct7Alt)) begin
                            w_dec.alu_control = AluSrxi;
                        end else begin
                            w_dec.illegal = 1'b1;
                        end
                    end
                endcase
            end
            default: begin
                w_dec.rs2     = w_rs2_f;
                w_dec.illegal = 1'b1;
            end
        endcase

        // Illegal entries must not write back or carry an operation
        if (w_dec.illegal) begin
            w_dec.alu_control = '0;
            w_dec.imm_val     = '0;
            w_dec.rd          = '0;
        end else begin
            w_dec.rd = w_rd_f;
        end
    end

    // Skid buffer state: main drives the outputs, skid catches one extra entry
    logic   r_main_valid;
    entry_t r_main;
    logic   r_skid_valid;
    entry_t r_skid;

    logic   w_main_valid_d;
    entry_t w_main_d;
    logic   w_skid_valid_d;
    entry_t w_skid_d;

    logic w_accept;
    logic w_consume;

    assign in_ready  = ~r_skid_valid;
    assign w_accept  = in_valid & in_ready;
    assign w_consume = r_main_valid & out_ready;

    // Buffer next state; flush overrides both accept and consume
    always_comb begin
        w_main_valid_d = r_main_valid;
        w_main_d       = r_main;
        w_skid_valid_d = r_skid_valid;
        w_skid_d       = r_skid;
        if (flush) begin
            w_main_valid_d = 1'b0;
            w_skid_valid_d = 1'b0;
        end else if (!r_main_valid || w_consume) begin
            // Main frees up: oldest pending entry (skid first) moves in
            if (r_skid_valid) begin
                w_main_d       = r_skid;
                w_main_valid_d = 1'b1;
                w_skid_valid_d = 1'b0;
            end else if (w_accept) begin
                w_main_d       = w_dec;
                w_main_valid_d = 1'b1;
            end else begin
                w_main_valid_d = 1'b0;
            end
        end else if (w_accept) begin
            // Main stalled: park the new entry in skid, which drops in_ready
            w_skid_d       = w_dec;
            w_skid_valid_d = 1'b1;
        end
    end

    // Buffer registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            r_main_valid <= 1'b0;
            r_main       <= '0;
            r_skid_valid <= 1'b0;
            r_skid       <= '0;
        end else begin
            r_main_valid <= w_main_valid_d;
            r_main       <= w_main_d;
            r_skid_valid <= w_skid_valid_d;
            r_skid       <= w_skid_d;
        end
    end

    assign out_valid       = r_main_valid;
    assign out_alu_control = r_main.alu_control;
    assign out_imm_val     = r_main.imm_val;
    assign out_rd          = r_main.rd;
    assign out_rs1         = r_main.rs1;
    assign out_rs2         = r_main.rs2;
    assign out_uses_rs2    = r_main.uses_rs2;
    assign out_illegal     = r_main.illegal;

`ifdef DECODE_ILLEGAL_CNT_EN
    logic [ILL_CNT_W-1:0] r_ill_cnt;

    // Count illegal accepts (even ones later flushed), saturating at all-ones
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ill_cnt <= '0;
        end else if (w_accept && w_dec.illegal && (r_ill_cnt != '1)) begin
            r_ill_cnt <= r_ill_cnt + ILL_CNT_W'(1);
        end
    end

    assign illegal_count = r_ill_cnt;
`else
    logic w_unused_ill_cnt_w;
    assign w_unused_ill_cnt_w = (ILL_CNT_W != 0);
`endif

endmodule

// File: tb/tb_alu_decode_stage.sv
// Self-checking bench for alu_decode_stage: directed cases plus randomized
// traffic compared every cycle against a queue-based reference model.
// Define DECODE_ILLEGAL_CNT_EN to also check illegal_count.
module tb_alu_decode_stage;

    localparam int unsigned ILL_CNT_W = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [5:0]  out_alu_control;
    logic [11:0] out_imm_val;
    logic [4:0]  out_rd;
    logic [4:0]  out_rs1;
    logic [4:0]  out_rs2;
    logic        out_uses_rs2;
    logic        out_illegal;
`ifdef DECODE_ILLEGAL_CNT_EN
    logic [ILL_CNT_W-1:0] illegal_count;
`endif

    alu_decode_stage #(
        .ILL_CNT_W(ILL_CNT_W)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_instr       (in_instr),
        .flush          (flush),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_alu_control(out_alu_control),
        .out_imm_val    (out_imm_val),
        .out_rd         (out_rd),
        .out_rs1        (out_rs1),
        .out_rs2        (out_rs2),
        .out_uses_rs2   (out_uses_rs2),
        .out_illegal    (out_illegal)
`ifdef DECODE_ILLEGAL_CNT_EN
        ,
        .illegal_count  (illegal_count)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [5:0]  alu;
        logic [11:0] imm;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic        uses;
        logic        ill;
    } dec_t;

    // ALU codes by funct3 for funct7=0 R-type and for I-type
    localparam logic [5:0] RTAB [8] = '{6'd0, 6'd6, 6'd1, 6'd2, 6'd5, 6'd7, 6'd4, 6'd3};
    localparam logic [5:0] ITAB [8] = '{6'd63, 6'd6, 6'd62, 6'd61, 6'd58, 6'd56, 6'd59, 6'd60};

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic dec_t model_decode(input logic [31:0] w);
        dec_t d;
        logic [6:0] op;
        logic [6:0] f7;
        logic [2:0] f3;
        logic ok;
        op = w[6:0];
        f3 = w[14:12];
        f7 = w[31:25];
        d  = '0;
        ok = 1'b0;
        d.rs1 = w[19:15];
        if (op == 7'h33) begin
            if (f7 == 7'h00) begin d.alu = RTAB[f3]; ok = 1'b1; end
            else if (f7 == 7'h20 && f3 == 3'd0) begin d.alu = 6'd8; ok = 1'b1; end
            else if (f7 == 7'h20 && f3 == 3'd5) begin d.alu = 6'd9; ok = 1'b1; end
            d.rd   = w[11:7];
            d.rs2  = w[24:20];
            d.uses = 1'b1;
        end else if (op == 7'h13) begin
            if (f3 == 3'd1)      ok = (f7 == 7'h00);
            else if (f3 == 3'd5) ok = (f7 == 7'h00) || (f7 == 7'h20);
            else                 ok = 1'b1;
            d.alu = ITAB[f3];
            d.imm = w[31:20];
            d.rd  = w[11:7];
        end
        if (!ok) begin
            d.alu = '0;
            d.imm = '0;
            d.rd  = '0;
            d.ill = 1'b1;
        end
        return d;
    endfunction

    // Reference model: queue of buffered entries, updated on each rising edge
    dec_t        q[$];
    int unsigned model_cnt = 0;
    logic        live      = 1'b0;
    logic        after_rst = 1'b0;

    always @(posedge clk) begin : model_upd
        logic acc;
        logic con;
        dec_t d;
        if (rst) begin
            q.delete();
            model_cnt = 0;
            after_rst = 1'b1;
        end else begin
            after_rst = 1'b0;
            acc = in_valid && (q.size() < 2);
            con = out_ready && (q.size() > 0);
            d   = model_decode(in_instr);
            if (acc && d.ill && model_cnt < (2 ** ILL_CNT_W) - 1) model_cnt++;
            if (flush) begin
                q.delete();
            end else begin
                if (con) void'(q.pop_front());
                if (acc) q.push_back(d);
            end
        end
        live = 1'b1;
    end

    // Compare DUT against the model on every falling edge
    always @(negedge clk) begin : compare
        dec_t e;
        if (live) begin
            check("in_ready", 64'(in_ready), 64'(q.size() < 2));
            check("out_valid", 64'(out_valid), 64'(q.size() != 0));
            if (q.size() != 0 && out_valid) begin
                e = q[0];
                check("alu_control", 64'(out_alu_control), 64'(e.alu));
                check("imm_val", 64'(out_imm_val), 64'(e.imm));
                check("rd", 64'(out_rd), 64'(e.rd));
                check("illegal", 64'(out_illegal), 64'(e.ill));
                if (!e.ill) begin
                    check("rs1", 64'(out_rs1), 64'(e.rs1));
                    check("rs2", 64'(out_rs2), 64'(e.rs2));
                    check("uses_rs2", 64'(out_uses_rs2), 64'(e.uses));
                end
            end
            if (after_rst) begin
                check("reset_fields", 64'({out_alu_control, out_imm_val, out_rd, out_rs1,
                      out_rs2, out_uses_rs2, out_illegal}), 64'(0));
            end
`ifdef DECODE_ILLEGAL_CNT_EN
            check("illegal_count", 64'(illegal_count), 64'(model_cnt));
`endif
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic xfer(input logic [31:0] ins);
        in_valid = 1'b1;
        in_instr = ins;
        step();
        in_valid = 1'b0;
    endtask

    function automatic logic [31:0] rand_instr();
        logic [31:0] w;
        int sel;
        w   = $urandom;
        sel = $urandom_range(0, 9);
        if (sel < 4)      w[6:0] = 7'h33;
        else if (sel < 8) w[6:0] = 7'h13;
        sel = $urandom_range(0, 3);
        if (sel == 0)      w[31:25] = 7'h00;
        else if (sel == 1) w[31:25] = 7'h20;
        return w;
    endfunction

    logic [31:0] bp[3];
    logic [4:0]  got[$];
    int          idx;
    logic        rdy;
    dec_t        pin;

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_instr  = '0;
        flush     = 1'b0;
        out_ready = 1'b0;

        // Pin the model with hand-computed decodes
        pin = model_decode(32'h002081B3);
        check("pin_add", 64'({pin.alu, pin.rd, pin.rs1, pin.rs2, pin.uses, pin.ill}),
              64'({6'd0, 5'd3, 5'd1, 5'd2, 1'b1, 1'b0}));
        pin = model_decode(32'h40315093);
        check("pin_srai", 64'({pin.alu, pin.imm, pin.rd, pin.ill}),
              64'({6'b111000, 12'h403, 5'd1, 1'b0}));
        pin = model_decode(32'hFE209093);
        check("pin_bad_slli", 64'({pin.ill, pin.alu, pin.rd}), 64'({1'b1, 6'd0, 5'd0}));

        step();
        step();
        check("rst_in_ready", 64'(in_ready), 64'(1));
        check("rst_out_valid", 64'(out_valid), 64'(0));
        rst = 1'b0;

        // ADD x3,x1,x2
        out_ready = 1'b1;
        xfer(32'h002081B3);
        check("add_valid", 64'(out_valid), 64'(1));
        check("add_fields", 64'({out_alu_control, out_rd, out_rs1, out_rs2, out_uses_rs2,
              out_imm_val}), 64'({6'd0, 5'd3, 5'd1, 5'd2, 1'b1, 12'd0}));
        step();

        // SUB then ADDI back to back
        in_valid = 1'b1;
        in_instr = 32'h402081B3;
        step();
        in_instr = 32'hFFF00293;
        check("sub_fields", 64'({out_valid, out_alu_control, out_rd}),
              64'({1'b1, 6'b001000, 5'd3}));
        step();
        in_valid = 1'b0;
        check("addi_fields", 64'({out_valid, out_alu_control, out_imm_val, out_rd, out_rs1,
              out_uses_rs2}), 64'({1'b1, 6'b111111, 12'hFFF, 5'd5, 5'd0, 1'b0}));
        step();

        // SRAI x1,x2,3
        xfer(32'h40315093);
        check("srai_fields", 64'({out_alu_control, out_imm_val, out_rd, out_rs1, out_illegal}),
              64'({6'b111000, 12'h403, 5'd1, 5'd2, 1'b0}));
        step();
        step();

        // Backpressure: three held instructions, only two fit
        bp[0] = 32'h002081B3;
        bp[1] = 32'h0020C233;
        bp[2] = 32'h00100313;
        out_ready = 1'b0;
        idx = 0;
        in_valid = 1'b1;
        in_instr = bp[0];
        for (int c = 0; c < 5; c++) begin
            rdy = in_ready;
            step();
            if (rdy) begin
                idx++;
                if (idx < 3) in_instr = bp[idx];
            end
        end
        check("bp_accepted", 64'(idx), 64'(2));
        check("bp_in_ready", 64'(in_ready), 64'(0));
        out_ready = 1'b1;
        got.delete();
        for (int c = 0; c < 12 && got.size() < 3; c++) begin
            rdy = in_ready;
            if (out_valid) got.push_back(out_rd);
            step();
            if (rdy && in_valid) begin
                idx++;
                if (idx < 3) in_instr = bp[idx];
                else in_valid = 1'b0;
            end
        end
        check("bp_count", 64'(got.size()), 64'(3));
        if (got.size() == 3) begin
            check("bp_order", 64'({got[0], got[1], got[2]}), 64'({5'd3, 5'd4, 5'd6}));
        end
        in_valid = 1'b0;
        step();
        check("bp_no_dup", 64'(out_valid), 64'(0));

        // Illegal instructions from a clean reset
        rst = 1'b1;
        step();
        rst = 1'b0;
        xfer(32'h00000000);
        check("ill0", 64'({out_illegal, out_rd, out_alu_control}), 64'({1'b1, 5'd0, 6'd0}));
        xfer(32'hFE209093);
        check("ill_slli", 64'({out_illegal, out_rd, out_alu_control}),
              64'({1'b1, 5'd0, 6'd0}));
`ifdef DECODE_ILLEGAL_CNT_EN
        check("ill_count2", 64'(illegal_count), 64'(2));
`endif
        step();

        // Flush with one entry buffered and a live handshake
        out_ready = 1'b0;
        xfer(32'h00500093);
        in_valid = 1'b1;
        in_instr = 32'h00700113;
        flush    = 1'b1;
        step();
        flush    = 1'b0;
        in_valid = 1'b0;
        check("flush1_state", 64'({out_valid, in_ready}), 64'({1'b0, 1'b1}));
        out_ready = 1'b1;
        step();
        check("flush1_gone", 64'(out_valid), 64'(0));

        // Flush with both entries full
        out_ready = 1'b0;
        xfer(32'h002081B3);
        xfer(32'h0020C233);
        check("full_in_ready", 64'(in_ready), 64'(0));
        in_valid = 1'b1;
        in_instr = 32'h00100313;
        flush    = 1'b1;
        step();
        flush    = 1'b0;
        in_valid = 1'b0;
        check("flush2_state", 64'({out_valid, in_ready}), 64'({1'b0, 1'b1}));
        out_ready = 1'b1;
        step();
        check("flush2_gone", 64'(out_valid), 64'(0));

        // Reset mid-stream
        out_ready = 1'b0;
        xfer(32'h402081B3);
        xfer(32'h00000000);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("midrst", 64'({out_valid, in_ready, out_alu_control, out_imm_val, out_rd}),
              64'({1'b0, 1'b1, 6'd0, 12'd0, 5'd0}));

        // Randomized traffic
        for (int c = 0; c < 3000; c++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            in_instr  = rand_instr();
            out_ready = ($urandom_range(0, 3) != 0);
            flush     = ($urandom_range(0, 24) == 0);
            rst       = ($urandom_range(0, 299) == 0);
            step();
        end
        in_valid = 1'b0;
        flush    = 1'b0;
        rst      = 1'b0;
        out_ready = 1'b1;
        step();
        step();
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_decode_stage.md
Name: alu_decode_stage

Overview:
- Decode stage feeding the ALU.
- Accepts 32-bit RV32I instructions over a valid/ready handshake and decodes the integer R-type and I-type ALU instructions into the 6-bit ALU control code, the 12-bit immediate and the register indices.
- Buffers results in a 2-entry skid buffer so `in_ready` is a registered signal.
- Sits between instruction fetch and the ALU/execute stage.

Parameters:
- ILL_CNT_W, 16, width of the saturating illegal-instruction counter (used only with the optional feature).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  instruction valid.
- in_ready  out  1  stage can accept; registered; equals "skid entry empty".
- in_instr  in  32  instruction word.
- flush  in  1  discard all buffered entries.
- out_valid  out  1  decoded entry valid.
- out_ready  in  1  consumer accepts.
- out_alu_control  out  6  ALU operation code.
- out_imm_val  out  12  immediate / shift-amount field.
- out_rd  out  5  destination register.
- out_rs1  out  5  source register 1.
- out_rs2  out  5  source register 2; 0 for I-type.
- out_uses_rs2  out  1  1 for R-type.
- out_illegal  out  1  instruction not decodable.
- illegal_count  out  ILL_CNT_W  present only with DECODE_ILLEGAL_CNT_EN.

Behaviour:
- Reset: `out_valid`=0, `in_ready`=1, all output fields 0, both entries empty, counter 0.
- Handshake: input accepted when `in_valid` && `in_ready`; output consumed when `out_valid` && `out_ready`.
- Latency: 1 cycle from accept to `out_valid` when the buffer is empty. Order is always preserved.
- Skid buffer holds a main entry (drives the outputs) and a skid entry:
  - Accept while main is empty, or main is consumed this cycle: the new entry goes to main.
  - Accept while main is full and not consumed: the new entry goes to skid, and `in_ready` goes 0 next cycle.
  - Main consumed while skid is full: skid moves to main, and `in_ready` returns to 1 next cycle.
- `flush`:
  - Both entries are invalidated at the next edge and `in_ready`=1.
  - An input handshake in the flush cycle is discarded.
  - `flush` takes priority over accept and consume.
- Decode for opcode 0110011 (R-type):
  - funct7=0000000, funct3 000/001/010/011/100/101/110/111 → ADD 000000, SLL 000110, SLT 000001, SLTU 000010, XOR 000101, SRL 000111, OR 000100, AND 000011.
  - funct7=0100000, funct3 000 → SUB 001000; funct3 101 → SRA 001001.
  - All other funct7/funct3 combinations → illegal.
  - `out_imm_val` = 0; shift amount for R-type shifts is supplied by the execute stage from the rs2 value.
- Decode for opcode 0010011 (I-type), `out_imm_val` = instr[31:20]:
  - funct3 000 ADDI 111111, 010 SLTI 111110, 011 SLTIU 111101, 100 XORI 111010, 110 ORI 111011, 111 ANDI 111100.
  - funct3 001 SLLI → 000110; requires instr[31:25]=0, else illegal.
  - funct3 101 SRLI/SRAI → 111000; requires instr[31:25] ∈ {0000000, 0100000}, else illegal.
- Any other opcode → illegal.
- Illegal entry: `out_illegal`=1, `out_alu_control`=000000, `out_imm_val`=0, `out_rd`=0 (no writeback), rs fields as decoded. It still passes through the handshake normally.

Optional Feature:
- DECODE_ILLEGAL_CNT_EN defined:
  - `illegal_count` port exists.
  - Increments by 1 on every accepted illegal instruction, counting at accept time, including accepts later flushed.
  - Saturates at all-ones; cleared only by `rst`.
- Undefined: the port and the counter logic are absent; all other behaviour is identical.

Test Plan:
- Send 0x002081B3 (ADD x3,x1,x2) with `out_ready`=1 → next cycle `out_valid`=1, alu_control 000000, rd 3, rs1 1, rs2 2, `out_uses_rs2`=1, imm 0.
- Send 0x402081B3, then 0xFFF00293 back-to-back → SUB 001000 rd 3; then ADDI 111111, imm 0xFFF, rd 5, rs1 0, `out_uses_rs2`=0.
- Send 0x40315093 (SRAI x1,x2,3) → alu_control 111000, imm 0x403, rd 1, rs1 2, not illegal.
- Backpressure: `out_ready`=0, `in_valid` held with three instructions:
  - Exactly 2 accepted; `in_ready`=0 from the cycle after the second accept.
  - Raise `out_ready` → all three emerge in order, none lost or duplicated.
- Send 0x00000000 and 0xFE209093 (SLLI with bad funct7):
  - Both give `out_illegal`=1, rd 0, alu_control 000000.
  - With DECODE_ILLEGAL_CNT_EN, `illegal_count`=2.
- Fill both entries, assert `flush` simultaneously with a new `in_valid` → next cycle `out_valid`=0, `in_ready`=1, and the flushed-cycle instruction never appears. Assert `rst` mid-stream → all outputs return to reset values next edge.
